// File: rtl/imem_loader.sv
// Boot-time byte-stream loader for the instruction memory; holds the core in reset until the program is loaded.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int CNT_W       = $clog2(DEPTH_WORDS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  input  logic             in_last,
  output logic             in_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             cpu_rst_n,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [1:0] {LOAD, CHECK, DONE, ERR} state_t;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH_WORDS);

  state_t      state;
  logic [1:0]  byte_idx;
  logic [23:0] asm_q;
  logic [31:0] word_next;
  logic        accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q;
`endif

  assign in_ready = (state == LOAD) || (state == CHECK);
  assign accept   = in_valid && in_ready;

  // Place the incoming byte after the held bytes; a short final word is zero-padded at the bottom.
  always_comb begin
    word_next = 32'h0;
    case (byte_idx)
      2'd0: word_next = {in_byte, 24'h0};
      2'd1: word_next = {asm_q[7:0], in_byte, 16'h0};
      2'd2: word_next = {asm_q[15:0], in_byte, 8'h0};
      2'd3: word_next = {asm_q, in_byte};
      default: word_next = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      byte_idx   <= 2'd0;
      asm_q      <= 24'h0;
      wr_en      <= 1'b0;
      wr_addr    <= 32'h0;
      wr_data    <= 32'h0;
      cpu_rst_n  <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= 8'h0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (accept) begin
        case (state)
          LOAD: begin
            if (word_count == FULL) begin
              // Memory already full: drop the byte, ignore in_last, and fail.
              state <= ERR;
              error <= 1'b1;
            end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              xor_q <= xor_q ^ in_byte;
`endif
              if (byte_idx == 2'd3 || in_last) begin
                wr_en      <= 1'b1;
                wr_addr    <= 32'({word_count, 2'b00});
                wr_data    <= word_next;
                word_count <= word_count + CNT_W'(1);
                byte_idx   <= 2'd0;
                asm_q      <= 24'h0;
              end else begin
                byte_idx <= byte_idx + 2'd1;
                asm_q    <= {asm_q[15:0], in_byte};
              end
              if (in_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= CHECK;
`else
                state     <= DONE;
                done      <= 1'b1;
                cpu_rst_n <= 1'b1;
`endif
              end
            end
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          CHECK: begin
            if (in_byte == xor_q) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a full-size and a 2-word instance share one byte stream.
// Honours IMEM_LOADER_CHECKSUM_EN the same way as the design.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_last;

  logic        big_ready, big_wr_en, big_rst_n, big_done, big_err;
  logic [31:0] big_addr, big_data;
  logic [8:0]  big_wc;
  logic        sml_ready, sml_wr_en, sml_rst_n, sml_done, sml_err;
  logic [31:0] sml_addr, sml_data;
  logic [1:0]  sml_wc;

  int checks = 0;
  int errors = 0;

  logic [7:0]  pres_b[$];
  bit          pres_l[$];
  logic [63:0] cap_big[$];
  logic [63:0] cap_sml[$];
  logic [63:0] mdl[$];

  typedef struct {
    string       name;
    int          n;
    int          last_pos;
    logic [95:0] bytes;
    bit          gaps;
    bit          big_done, big_err;
    int          big_cnt;
    bit          sml_done, sml_err;
    int          sml_cnt;
    int          nw;
    logic [31:0] w0, w1;
  } vec_t;

  vec_t vecs[4];

  imem_loader #(.DEPTH_WORDS(256)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last),
    .in_ready(big_ready), .wr_en(big_wr_en), .wr_addr(big_addr), .wr_data(big_data),
    .cpu_rst_n(big_rst_n), .done(big_done), .error(big_err), .word_count(big_wc)
  );

  imem_loader #(.DEPTH_WORDS(2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last),
    .in_ready(sml_ready), .wr_en(sml_wr_en), .wr_addr(sml_addr), .wr_data(sml_data),
    .cpu_rst_n(sml_rst_n), .done(sml_done), .error(sml_err), .word_count(sml_wc)
  );

  always #5 clk = ~clk;

  // Every negedge with wr_en high is one memory write.
  always @(negedge clk) begin
    if (big_wr_en) cap_big.push_back({big_addr, big_data});
    if (sml_wr_en) cap_sml.push_back({sml_addr, sml_data});
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit last);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    pres_b.push_back(b);
    pres_l.push_back(last);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) begin
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      in_last  = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pres_b.delete();
    pres_l.delete();
    cap_big.delete();
    cap_sml.delete();
  endtask

  // Reference: bytes fill words in order; a word is emitted when it has four bytes or the last one arrives.
  task automatic run_model(input int depth, output int cnt, output bit dn, output bit er);
    logic [7:0]  wb[$];
    logic [7:0]  x;
    logic [31:0] w;
    bit          term, chk;
    mdl.delete();
    cnt = 0; dn = 0; er = 0; x = 8'h0; term = 0; chk = 0;
    for (int i = 0; i < pres_b.size(); i++) begin
      if (term) continue;
      if (chk) begin
        if (pres_b[i] == x) dn = 1; else er = 1;
        term = 1;
        continue;
      end
      if (cnt == depth) begin
        er = 1;
        term = 1;
        continue;
      end
      wb.push_back(pres_b[i]);
      x = x ^ pres_b[i];
      if (wb.size() == 4 || pres_l[i]) begin
        w = 32'h0;
        for (int k = 0; k < wb.size(); k++) w[31-8*k -: 8] = wb[k];
        mdl.push_back({32'(cnt * 4), w});
        cnt++;
        wb.delete();
      end
      if (pres_l[i]) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk = 1;
`else
        dn = 1;
        term = 1;
`endif
      end
    end
  endtask

  task automatic compare_dut(input string tag, input int depth, input logic d, input logic e,
                             input logic rn, input logic rdy, input logic [31:0] wc,
                             input logic [63:0] cap[$]);
    int cnt;
    bit dn, er;
    run_model(depth, cnt, dn, er);
    checkOutput({tag, " done"}, 32'(d), 32'(dn));
    checkOutput({tag, " error"}, 32'(e), 32'(er));
    checkOutput({tag, " cpu_rst_n"}, 32'(rn), 32'(dn));
    checkOutput({tag, " in_ready"}, 32'(rdy), 32'(!(dn || er)));
    checkOutput({tag, " word_count"}, wc, 32'(cnt));
    checkOutput({tag, " nwrites"}, 32'(cap.size()), 32'(mdl.size()));
    for (int k = 0; k < mdl.size() && k < cap.size(); k++) begin
      checkOutput({tag, " wr_addr"}, cap[k][63:32], mdl[k][63:32]);
      checkOutput({tag, " wr_data"}, cap[k][31:0], mdl[k][31:0]);
    end
  endtask

  task automatic set_vec(input int i, input string name, input int n, input int lp,
                         input logic [95:0] bytes, input bit gaps,
                         input bit bd, input bit be, input int bc,
                         input bit sd, input bit se, input int sc,
                         input int nw, input logic [31:0] w0, input logic [31:0] w1);
    vecs[i].name = name;   vecs[i].n = n;         vecs[i].last_pos = lp;
    vecs[i].bytes = bytes; vecs[i].gaps = gaps;
    vecs[i].big_done = bd; vecs[i].big_err = be;  vecs[i].big_cnt = bc;
    vecs[i].sml_done = sd; vecs[i].sml_err = se;  vecs[i].sml_cnt = sc;
    vecs[i].nw = nw;       vecs[i].w0 = w0;       vecs[i].w1 = w1;
  endtask

  initial begin
    logic [7:0] b, x;
    int         len;
    rst = 1'b0; in_valid = 1'b0; in_byte = 8'h0; in_last = 1'b0;

`ifdef IMEM_LOADER_CHECKSUM_EN
    set_vec(0, "csum_ok",  5, 3, 96'h01020304_04000000_00000000, 0, 1, 0, 1, 1, 0, 1, 1, 32'h01020304, 32'h0);
    set_vec(1, "csum_bad", 5, 3, 96'h01020304_05000000_00000000, 0, 0, 1, 1, 0, 1, 1, 1, 32'h01020304, 32'h0);
    set_vec(2, "overflow", 10, 8, 96'h01020304_05060708_09010000, 0, 1, 0, 3, 0, 1, 2, 3, 32'h01020304, 32'h05060708);
    set_vec(3, "partial",  6, 4, 96'hABCDEF01_23AB0000_00000000, 1, 1, 0, 2, 1, 0, 2, 2, 32'hABCDEF01, 32'h23000000);
`else
    set_vec(0, "normal",   8, 7, 96'h20080005_2109FFFF_00000000, 0, 1, 0, 2, 1, 0, 2, 2, 32'h20080005, 32'h2109FFFF);
    set_vec(1, "partial",  5, 4, 96'hABCDEF01_23000000_00000000, 1, 1, 0, 2, 1, 0, 2, 2, 32'hABCDEF01, 32'h23000000);
    set_vec(2, "overflow", 9, 8, 96'h01020304_05060708_09000000, 0, 1, 0, 3, 0, 1, 2, 3, 32'h01020304, 32'h05060708);
    set_vec(3, "single",   1, 0, 96'h5A000000_00000000_00000000, 0, 1, 0, 1, 1, 0, 1, 1, 32'h5A000000, 32'h0);
`endif

    @(negedge clk);
    do_reset();
    checkOutput("reset in_ready", 32'(big_ready), 32'd1);
    checkOutput("reset wr_en", 32'(big_wr_en), 32'd0);
    checkOutput("reset wr_addr", big_addr, 32'h0);
    checkOutput("reset wr_data", big_data, 32'h0);
    checkOutput("reset cpu_rst_n", 32'(big_rst_n), 32'd0);
    checkOutput("reset done", 32'(big_done), 32'd0);
    checkOutput("reset error", 32'(big_err), 32'd0);
    checkOutput("reset word_count", 32'(big_wc), 32'd0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n; i++) begin
        if (i == vecs[v].n - 1) begin
          checkOutput({vecs[v].name, " done early"}, 32'(big_done), 32'd0);
          checkOutput({vecs[v].name, " error early"}, 32'(big_err), 32'd0);
        end
        applyStimulus(vecs[v].bytes[95-8*i -: 8], i == vecs[v].last_pos);
        if (vecs[v].gaps && i < vecs[v].n - 1) idle_cycles($urandom_range(0, 2));
      end
      // Status must be visible in the cycle right after the terminating byte.
      checkOutput({vecs[v].name, " done latency"}, 32'(big_done), 32'(vecs[v].big_done));
      checkOutput({vecs[v].name, " error latency"}, 32'(big_err), 32'(vecs[v].big_err));
      if (v == 0) begin
        checkOutput("final cpu_rst_n", 32'(big_rst_n), 32'd1);
`ifndef IMEM_LOADER_CHECKSUM_EN
        checkOutput("final wr_en", 32'(big_wr_en), 32'd1);
        checkOutput("final wr_addr", big_addr, 32'h4);
        checkOutput("final wr_data", big_data, 32'h2109FFFF);
        checkOutput("final word_count", 32'(big_wc), 32'd2);
`endif
      end
      idle_cycles(3);
      checkOutput({vecs[v].name, " big done"}, 32'(big_done), 32'(vecs[v].big_done));
      checkOutput({vecs[v].name, " big error"}, 32'(big_err), 32'(vecs[v].big_err));
      checkOutput({vecs[v].name, " big count"}, 32'(big_wc), 32'(vecs[v].big_cnt));
      checkOutput({vecs[v].name, " big nwrites"}, 32'(cap_big.size()), 32'(vecs[v].nw));
      if (cap_big.size() > 0) checkOutput({vecs[v].name, " big w0"}, cap_big[0][31:0], vecs[v].w0);
      if (cap_big.size() > 1 && vecs[v].nw > 1)
        checkOutput({vecs[v].name, " big w1"}, cap_big[1][31:0], vecs[v].w1);
      checkOutput({vecs[v].name, " small done"}, 32'(sml_done), 32'(vecs[v].sml_done));
      checkOutput({vecs[v].name, " small error"}, 32'(sml_err), 32'(vecs[v].sml_err));
      checkOutput({vecs[v].name, " small count"}, 32'(sml_wc), 32'(vecs[v].sml_cnt));
      checkOutput({vecs[v].name, " small cpu_rst_n"}, 32'(sml_rst_n), 32'(vecs[v].sml_done));
      compare_dut({vecs[v].name, " big"}, 256, big_done, big_err, big_rst_n, big_ready, 32'(big_wc), cap_big);
      compare_dut({vecs[v].name, " small"}, 2, sml_done, sml_err, sml_rst_n, sml_ready, 32'(sml_wc), cap_sml);
    end

    // Reset in the middle of a word must not leak stale bytes into the next load.
    do_reset();
    for (int i = 0; i < 6; i++) applyStimulus(8'(8'hA0 + i), 1'b0);
    do_reset();
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    applyStimulus(8'h33, 1'b0);
    applyStimulus(8'h44, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(8'h44, 1'b0);
`endif
    idle_cycles(3);
    checkOutput("midreset nwrites", 32'(cap_big.size()), 32'd1);
    if (cap_big.size() > 0) begin
      checkOutput("midreset addr", cap_big[0][63:32], 32'h0);
      checkOutput("midreset data", cap_big[0][31:0], 32'h11223344);
    end
    checkOutput("midreset count", 32'(big_wc), 32'd1);
    checkOutput("midreset done", 32'(big_done), 32'd1);

    // Randomized loads with gaps and trailing bytes that must be refused.
    for (int it = 0; it < 30; it++) begin
      do_reset();
      len = $urandom_range(1, 11);
      x = 8'h0;
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        x = x ^ b;
        applyStimulus(b, i == len - 1);
        idle_cycles($urandom_range(0, 1));
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      applyStimulus($urandom_range(0, 1) ? x : (x ^ 8'h5A), 1'($urandom));
`endif
      repeat ($urandom_range(0, 2)) applyStimulus(8'($urandom), 1'($urandom));
      idle_cycles(3);
      compare_dut("rand big", 256, big_done, big_err, big_rst_n, big_ready, 32'(big_wc), cap_big);
      compare_dut("rand small", 2, sml_done, sml_err, sml_rst_n, sml_ready, 32'(sml_wc), cap_sml);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
